// File: rtl/grf_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : grf_scoreboard
//  Description : 32x32 register file with two combinational read ports,
//                same-cycle write bypass and a per-register pending-write
//                scoreboard that produces the D-stage operand stall.
//  Revision    : 1.0 - initial release
// ============================================================================

module grf_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        use_rs,
    input  logic        use_rt,
    input  logic        issue_valid,
    input  logic [4:0]  issue_dst,
    output logic        stall,
    output logic        pend_ovf
);

    localparam logic [CNT_W-1:0] c_cntMax  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cntOne  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cntZero = '0;

    logic              w_wrEn;
    logic              w_incEn;
    logic [31:0]       w_regView [0:31];
    logic [CNT_W-1:0]  w_cntView [0:31];
    logic [31:0]       w_ovfVec;
    logic              r_pendOvf;

    logic              w_byp1;
    logic              w_byp2;
    logic [CNT_W-1:0]  w_cntRa1;
    logic [CNT_W-1:0]  w_cntRa2;
    logic              w_haz1;
    logic              w_haz2;

    assign w_wrEn  = we && (wa != 5'd0);
    assign w_incEn = issue_valid && (issue_dst != 5'd0);

    // Register 0 is hardwired: zero data, never pending, never overflows.
    assign w_regView[0] = '0;
    assign w_cntView[0] = c_cntZero;
    assign w_ovfVec[0]  = 1'b0;

    for (genvar gi = 1; gi < 32; gi++) begin : g_entry
        logic [31:0]      r_data;
        logic [CNT_W-1:0] r_cnt;
        logic             w_inc;
        logic             w_dec;

        assign w_inc = w_incEn && (issue_dst == 5'(gi));
        assign w_dec = w_wrEn && (wa == 5'(gi));

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_data <= '0;
            end else if (w_dec) begin
                r_data <= wd;
            end
        end

        // A retire with nothing pending is an untracked write: data lands, count holds at 0.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt <= c_cntZero;
            end else if (w_inc && !w_dec) begin
                if (r_cnt != c_cntMax) begin
                    r_cnt <= r_cnt + c_cntOne;
                end
            end else if (w_dec && !w_inc) begin
                if (r_cnt != c_cntZero) begin
                    r_cnt <= r_cnt - c_cntOne;
                end
            end
        end

        assign w_ovfVec[gi]  = w_inc && !w_dec && (r_cnt == c_cntMax);
        assign w_regView[gi] = r_data;
        assign w_cntView[gi] = r_cnt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pendOvf <= 1'b0;
        end else if (|w_ovfVec) begin
            r_pendOvf <= 1'b1;
        end
    end

    assign w_byp1 = we && (wa == ra1);
    assign w_byp2 = we && (wa == ra2);

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : (w_byp1 ? wd : w_regView[ra1]);
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : (w_byp2 ? wd : w_regView[ra2]);

    assign w_cntRa1 = w_cntView[ra1];
    assign w_cntRa2 = w_cntView[ra2];

    // The final retiring write is forwarded by the bypass, so it does not stall.
    assign w_haz1 = use_rs && (ra1 != 5'd0) && (w_cntRa1 != c_cntZero)
                    && !(w_byp1 && (w_cntRa1 == c_cntOne));
    assign w_haz2 = use_rt && (ra2 != 5'd0) && (w_cntRa2 != c_cntZero)
                    && !(w_byp2 && (w_cntRa2 == c_cntOne));

    assign stall    = w_haz1 || w_haz2;
    assign pend_ovf = r_pendOvf;

endmodule

`default_nettype wire
